vram_writer: RTL and testbench
==============================

Name: vram_writer

Overview:
- Host-side command engine that drives the write port of the dual-port display memory (wr_en / wr_address / wr_data). The video scanout drives the read port.
- Accepts commands over a valid/ready handshake: set address, set increment, single write with auto-increment, and block fill.
- Serialises all commands into at most one memory write per clock.
- Sits between the host/UART command decoder and the display memory, in the memory's write-clock domain.

Parameters:
ADDR_W, 10, memory address width in words; must match the memory instance.
DATA_W, 8, memory word width; must match the memory instance.

Ports:
clk  input  1  single clock; the memory wr_clk is tied to it.
reset_i  input  1  asynchronous, active-high reset.
cmd_valid_i  input  1  command present.
cmd_ready_o  output  1  engine can accept a command this cycle.
cmd_op_i  input  2  0=SET_ADDR, 1=WRITE, 2=FILL, 3=SET_INC.
cmd_addr_i  input  ADDR_W  address for SET_ADDR, increment for SET_INC.
cmd_data_i  input  DATA_W  data for WRITE and FILL.
cmd_count_i  input  ADDR_W  FILL word count minus 1.
abort_i  input  1  terminate an in-progress FILL.
busy_o  output  1  FILL in progress.
cur_addr_o  output  ADDR_W  next address to be written.
wr_en_o  output  1  memory write enable.
wr_address_o  output  ADDR_W  memory write address.
wr_data_o  output  DATA_W  memory write data.

Behaviour:
- Reset (async assert, sync release): state=IDLE, cur_addr=0, inc=1, remaining=0, wr_en_o=0, wr_address_o=0, wr_data_o=0, busy_o=0. cmd_ready_o=0 while reset_i is high.
- Accept rule: a command is accepted on a rising clk edge when cmd_valid_i && cmd_ready_o. cmd_ready_o = (state==IDLE) && !reset_i, combinational from registered state. Inputs are ignored when not accepted.
- All wr_* outputs are registered. A write issued at edge N appears on wr_* during cycle N+1 and is committed to memory at edge N+1. wr_en_o is high for exactly one cycle per word.
- wr_address_o and wr_data_o hold their last values when wr_en_o=0.
- SET_ADDR: cur_addr <= cmd_addr_i. No write.
- SET_INC: inc <= cmd_addr_i. No write. inc=0 is legal and gives repeated writes to the same address.
- WRITE: wr_en_o<=1, wr_address_o<=cur_addr, wr_data_o<=cmd_data_i, cur_addr<=cur_addr+inc.
- Address arithmetic is modulo 2^ADDR_W and wraps silently.
- Back-to-back WRITEs are accepted every cycle (ready stays high), giving one write per cycle.
- FILL: N = cmd_count_i+1 words, range 1..2^ADDR_W.
  - At the accept edge: the first write is issued as for WRITE, and fill_data<=cmd_data_i.
  - If cmd_count_i==0: remain IDLE.
  - Otherwise: state<=FILL, remaining<=cmd_count_i.
- FILL state:
  - busy_o=1 and cmd_ready_o=0.
  - Each edge: write fill_data at cur_addr, cur_addr+=inc, remaining-=1. Transition to IDLE on the edge where remaining goes 1->0.
  - Result: ready is low for exactly cmd_count_i cycles after accept, and N consecutive wr_en_o cycles are produced.
- abort_i sampled high in FILL: no write on that edge, state<=IDLE, remaining<=0. cur_addr keeps the next unwritten address. abort_i is ignored in IDLE.
- Simultaneous abort_i and the final fill edge: abort wins; that word is not written.
- Full-memory fill (cmd_count_i all ones): 2^ADDR_W writes; cur_addr returns to its start value when inc=1.
- cur_addr_o = cur_addr (registered). busy_o = (state==FILL).
- Reset mid-FILL: outputs return to reset values immediately (wr_en_o drops asynchronously). No further writes are issued.

Test Plan:
1. Reset, then WRITE data=0x5A, then WRITE 0x3C on consecutive cycles -> wr_en_o high 2 cycles at addresses 0,1; readback mem[0]=0x5A, mem[1]=0x3C; cur_addr_o=2.
2. SET_ADDR 0x3FE, SET_INC 1, three WRITEs 0x11,0x22,0x33 -> addresses 0x3FE,0x3FF,0x000 (wrap); cur_addr_o=0x001.
3. SET_ADDR 0x100, SET_INC 4, FILL count=7 data=0xA5 -> cmd_ready_o low 7 cycles; 8 writes at 0x100..0x11C step 4; busy_o drops with the last write; cur_addr_o=0x120.
4. FILL count=0x3FF data=0x00 from address 0 -> exactly 1024 wr_en_o cycles; every word reads 0x00; cur_addr_o=0.
5. FILL count=15, assert abort_i on the 5th cycle after accept -> exactly 5 writes (addresses 0..4); cmd_ready_o high the next cycle; cur_addr_o=5; a following WRITE goes to address 5.
6. Assert reset_i mid-FILL between clock edges -> wr_en_o and busy_o fall immediately; after release cur_addr_o=0, inc=1, and the first WRITE goes to address 0.

Source files
------------

// File: rtl/vram_writer.sv
// ---------------------------------------------------------------------------
// vram_writer
//
// Host-side command engine for the write port of the dual-port display
// memory. Commands arrive over a valid/ready handshake and are turned into at
// most one memory write per clock. The video scanout owns the read port.
//
// Commands (cmd_op_i):
//   0 SET_ADDR : cur_addr <= cmd_addr_i
//   1 WRITE    : write cmd_data_i at cur_addr, cur_addr += inc
//   2 FILL     : write cmd_data_i to cmd_count_i+1 consecutive words
//                (stride inc). The first word goes out on the accept edge.
//   3 SET_INC  : inc <= cmd_addr_i (0 is legal: same address repeatedly)
//
// Ports:
//   clk            clock; the memory write clock is tied to it
//   reset_i        asynchronous active-high reset
//   cmd_valid_i    command present
//   cmd_ready_o    engine can accept a command this cycle
//   cmd_op_i       command opcode
//   cmd_addr_i     address (SET_ADDR) or increment (SET_INC)
//   cmd_data_i     data for WRITE / FILL
//   cmd_count_i    FILL word count minus one
//   abort_i        stops an in-progress FILL; ignored when idle
//   busy_o         FILL in progress
//   cur_addr_o     next address to be written
//   wr_en_o        memory write enable (one cycle per word)
//   wr_address_o   memory write address (holds while wr_en_o is low)
//   wr_data_o      memory write data    (holds while wr_en_o is low)
// ---------------------------------------------------------------------------
module vram_writer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    input  logic [ADDR_W-1:0] cmd_count_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic [ADDR_W-1:0] cur_addr_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_address_o,
    output logic [DATA_W-1:0] wr_data_o
);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam logic [1:0] OP_SET_ADDR = 2'd0;
    localparam logic [1:0] OP_WRITE    = 2'd1;
    localparam logic [1:0] OP_FILL     = 2'd2;
    localparam logic [1:0] OP_SET_INC  = 2'd3;

    state_t              state_reg,      state_next;
    logic [ADDR_W-1:0]   cur_addr_reg,   cur_addr_next;
    logic [ADDR_W-1:0]   inc_reg,        inc_next;
    logic [ADDR_W-1:0]   remaining_reg,  remaining_next;
    logic [DATA_W-1:0]   fill_data_reg,  fill_data_next;
    logic                wr_en_reg,      wr_en_next;
    logic [ADDR_W-1:0]   wr_address_reg, wr_address_next;
    logic [DATA_W-1:0]   wr_data_reg,    wr_data_next;
    logic                accept;

    // Ready depends only on registered state (plus reset), so it never
    // combinationally depends on cmd_valid_i.
    assign cmd_ready_o = (state_reg == IDLE) && !reset_i;
    assign accept      = cmd_valid_i && cmd_ready_o;

    assign busy_o       = (state_reg == FILL);
    assign cur_addr_o   = cur_addr_reg;
    assign wr_en_o      = wr_en_reg;
    assign wr_address_o = wr_address_reg;
    assign wr_data_o    = wr_data_reg;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_reg      <= IDLE;
            cur_addr_reg   <= '0;
            inc_reg        <= {{(ADDR_W-1){1'b0}}, 1'b1};
            remaining_reg  <= '0;
            fill_data_reg  <= '0;
            wr_en_reg      <= 1'b0;
            wr_address_reg <= '0;
            wr_data_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            cur_addr_reg   <= cur_addr_next;
            inc_reg        <= inc_next;
            remaining_reg  <= remaining_next;
            fill_data_reg  <= fill_data_next;
            wr_en_reg      <= wr_en_next;
            wr_address_reg <= wr_address_next;
            wr_data_reg    <= wr_data_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cur_addr_next   = cur_addr_reg;
        inc_next        = inc_reg;
        remaining_next  = remaining_reg;
        fill_data_next  = fill_data_reg;
        wr_en_next      = 1'b0;
        // Address/data hold their last value when no write is issued.
        wr_address_next = wr_address_reg;
        wr_data_next    = wr_data_reg;

        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    unique case (cmd_op_i)
                        OP_SET_ADDR: cur_addr_next = cmd_addr_i;
                        OP_SET_INC:  inc_next      = cmd_addr_i;
                        OP_WRITE: begin
                            wr_en_next      = 1'b1;
                            wr_address_next = cur_addr_reg;
                            wr_data_next    = cmd_data_i;
                            cur_addr_next   = cur_addr_reg + inc_reg;
                        end
                        OP_FILL: begin
                            // First word is written on the accept edge, so a
                            // count of zero is a single write that never
                            // leaves IDLE.
                            wr_en_next      = 1'b1;
                            wr_address_next = cur_addr_reg;
                            wr_data_next    = cmd_data_i;
                            cur_addr_next   = cur_addr_reg + inc_reg;
                            fill_data_next  = cmd_data_i;
                            if (cmd_count_i != '0) begin
                                state_next     = FILL;
                                remaining_next = cmd_count_i;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            FILL: begin
                if (abort_i) begin
                    // Abort beats the write on the same edge, so cur_addr
                    // still names the first unwritten word.
                    state_next     = IDLE;
                    remaining_next = '0;
                end else begin
                    wr_en_next      = 1'b1;
                    wr_address_next = cur_addr_reg;
                    wr_data_next    = fill_data_reg;
                    cur_addr_next   = cur_addr_reg + inc_reg;
                    remaining_next  = remaining_reg - 1'b1;
                    if (remaining_reg == {{(ADDR_W-1){1'b0}}, 1'b1}) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vram_writer.sv
// ---------------------------------------------------------------------------
// tb_vram_writer
//
// Self-checking bench for vram_writer. A reference model of the command
// engine pushes expected {address,data} writes into a queue as commands are
// driven; a monitor pops and compares on every wr_en_o cycle. A behavioural
// memory captures committed writes for readback checks.
// ---------------------------------------------------------------------------
module tb_vram_writer;

    localparam int AW = 10;
    localparam int DW = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk;
    logic          reset_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [1:0]    cmd_op_i;
    logic [AW-1:0] cmd_addr_i;
    logic [DW-1:0] cmd_data_i;
    logic [AW-1:0] cmd_count_i;
    logic          abort_i;
    logic          busy_o;
    logic [AW-1:0] cur_addr_o;
    logic          wr_en_o;
    logic [AW-1:0] wr_address_o;
    logic [DW-1:0] wr_data_o;

    vram_writer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset_i      (reset_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_op_i     (cmd_op_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_data_i   (cmd_data_i),
        .cmd_count_i  (cmd_count_i),
        .abort_i      (abort_i),
        .busy_o       (busy_o),
        .cur_addr_o   (cur_addr_o),
        .wr_en_o      (wr_en_o),
        .wr_address_o (wr_address_o),
        .wr_data_o    (wr_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_compared = 0;
    int            n_mismatch = 0;
    int            wr_cnt     = 0;
    exp_t          q[$];
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] m_addr;
    logic [AW-1:0] m_inc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural memory: commits on the edge after wr_en_o rises.
    always @(posedge clk) begin
        if (wr_en_o === 1'b1) mem[wr_address_o] <= wr_data_o;
    end

    // Scoreboard monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_en_o === 1'b1) begin
            exp_t e;
            wr_cnt++;
            if (q.size() == 0) begin
                chk("spurious_wr", {31'd0, wr_en_o}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("wr_addr", {22'd0, wr_address_o}, {22'd0, e.addr});
                chk("wr_data", {24'd0, wr_data_o}, {24'd0, e.data});
            end
        end
    end

    // Drives one command and updates the model. Called at posedge+1; returns
    // at posedge+1 right after the accept edge. 'limit' caps the number of
    // FILL writes the model expects (used when the fill is aborted).
    task automatic send(input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [AW-1:0] cnt,
                        input int limit = 1 << 20);
        int g = 0;
        int n;
        $display("cmd op=%0d addr=%h data=%h count=%0d", op, a, d, cnt);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_addr_i  = a;
        cmd_data_i  = d;
        cmd_count_i = cnt;
        while (cmd_ready_o !== 1'b1 && g < 200) begin
            @(posedge clk); #1; g++;
        end
        chk("cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
        case (op)
            2'd0: m_addr = a;
            2'd3: m_inc  = a;
            2'd1: begin
                q.push_back('{addr: m_addr, data: d});
                m_addr = m_addr + m_inc;
            end
            default: begin
                n = int'(cnt) + 1;
                if (n > limit) n = limit;
                for (int i = 0; i < n; i++) begin
                    q.push_back('{addr: m_addr, data: d});
                    m_addr = m_addr + m_inc;
                end
            end
        endcase
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (q.size() != 0 && g < 3000) begin
            @(negedge clk); #1; g++;
        end
        chk("drain", q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int low;
        int g;
        int bad;

        reset_i     = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_op_i    = 2'd0;
        cmd_addr_i  = '0;
        cmd_data_i  = '0;
        cmd_count_i = '0;
        abort_i     = 1'b0;
        m_addr      = '0;
        m_inc       = 10'd1;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'hFF;

        #12;
        chk("rst_ready", {31'd0, cmd_ready_o}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en_o}, 32'd0);
        chk("rst_busy",  {31'd0, busy_o}, 32'd0);
        chk("rst_addr",  {22'd0, cur_addr_o}, 32'd0);
        @(negedge clk) reset_i = 1'b0;
        @(posedge clk); #1;

        // 1: two back-to-back writes from address 0
        wr_cnt = 0;
        send(2'd1, '0, 8'h5A, '0);
        send(2'd1, '0, 8'h3C, '0);
        drain();
        chk("t1_wr_cnt", wr_cnt, 2);
        chk("t1_mem0", {24'd0, mem[0]}, 32'h5A);
        chk("t1_mem1", {24'd0, mem[1]}, 32'h3C);
        chk("t1_cur_addr", {22'd0, cur_addr_o}, 32'd2);

        // 2: address wrap
        send(2'd0, 10'h3FE, '0, '0);
        send(2'd3, 10'd1, '0, '0);
        send(2'd1, '0, 8'h11, '0);
        send(2'd1, '0, 8'h22, '0);
        send(2'd1, '0, 8'h33, '0);
        drain();
        chk("t2_mem_3ff", {24'd0, mem[10'h3FF]}, 32'h22);
        chk("t2_mem_000", {24'd0, mem[0]}, 32'h33);
        chk("t2_cur_addr", {22'd0, cur_addr_o}, 32'h001);

        // 3: strided fill of 8 words
        send(2'd0, 10'h100, '0, '0);
        send(2'd3, 10'd4, '0, '0);
        wr_cnt = 0;
        send(2'd2, '0, 8'hA5, 10'd7);
        low = 0;
        g = 0;
        while (cmd_ready_o !== 1'b1 && g < 50) begin
            chk("t3_busy", {31'd0, busy_o}, 32'd1);
            low++;
            @(posedge clk); #1; g++;
        end
        chk("t3_ready_low", low, 7);
        chk("t3_busy_end", {31'd0, busy_o}, 32'd0);
        chk("t3_last_wr", {31'd0, wr_en_o}, 32'd1);
        drain();
        chk("t3_wr_cnt", wr_cnt, 8);
        chk("t3_cur_addr", {22'd0, cur_addr_o}, 32'h120);
        chk("t3_mem_11c", {24'd0, mem[10'h11C]}, 32'hA5);

        // 4: full-memory fill with zeros
        send(2'd0, '0, '0, '0);
        send(2'd3, 10'd1, '0, '0);
        wr_cnt = 0;
        send(2'd2, '0, 8'h00, 10'h3FF);
        drain();
        chk("t4_wr_cnt", wr_cnt, 1024);
        bad = 0;
        for (int i = 0; i < (1 << AW); i++) if (mem[i] !== 8'h00) bad++;
        chk("t4_nonzero_words", bad, 0);
        chk("t4_cur_addr", {22'd0, cur_addr_o}, 32'd0);

        // 5: abort on the 5th cycle after accept
        wr_cnt = 0;
        send(2'd2, '0, 8'hC3, 10'd15, 5);
        repeat (4) @(posedge clk);
        #1 abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        chk("t5_ready_after_abort", {31'd0, cmd_ready_o}, 32'd1);
        chk("t5_cur_addr", {22'd0, cur_addr_o}, 32'd5);
        send(2'd1, '0, 8'h99, '0);
        drain();
        chk("t5_wr_cnt", wr_cnt, 6);
        chk("t5_mem5", {24'd0, mem[5]}, 32'h99);
        chk("t5_mem6", {24'd0, mem[6]}, 32'h00);

        // 6: asynchronous reset in the middle of a fill
        send(2'd2, '0, 8'hEE, 10'd15);
        repeat (3) @(posedge clk);
        chk("t6_busy_pre", {31'd0, busy_o}, 32'd1);
        #2 reset_i = 1'b1;
        #1;
        chk("t6_wr_en", {31'd0, wr_en_o}, 32'd0);
        chk("t6_busy", {31'd0, busy_o}, 32'd0);
        chk("t6_ready", {31'd0, cmd_ready_o}, 32'd0);
        chk("t6_wr_addr", {22'd0, wr_address_o}, 32'd0);
        q.delete();
        m_addr = '0;
        m_inc  = 10'd1;
        wr_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_i = 1'b0;
        #1;
        chk("t6_cur_addr", {22'd0, cur_addr_o}, 32'd0);
        chk("t6_no_wr_in_reset", wr_cnt, 0);
        @(posedge clk); #1;
        send(2'd1, '0, 8'h77, '0);
        send(2'd1, '0, 8'h78, '0);
        drain();
        chk("t6_wr_cnt", wr_cnt, 2);
        chk("t6_mem0", {24'd0, mem[0]}, 32'h77);
        chk("t6_mem1", {24'd0, mem[1]}, 32'h78);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
